// File: rtl/rv32_d_regfile_pkg.sv
// Shared constants and FSM state encoding for the multi-ported RV32 register file.
package rv32_d_regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    // INIT sweeps zeros into storage, RUN serves normal traffic.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rv32_d_regfile_wr_arb.sv
// Same-cycle write lookup for one read port.
// Scans the write ports in ascending order so that the highest-numbered
// matching port wins. This mirrors the storage update order in the top.
module rv32_d_regfile_wr_arb #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NUM_WR = 2
) (
    input  logic [AW-1:0]                  read_address,
    input  logic [NUM_WR-1:0]              write_valid,
    input  logic [NUM_WR-1:0][AW-1:0]      write_address,
    input  logic [NUM_WR-1:0][XLEN-1:0]    write_data,
    output logic                           hit,
    output logic [XLEN-1:0]                data
);

    // Later ports overwrite earlier matches, which gives highest-port priority.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (write_valid[p] && (write_address[p] == read_address)) begin
                hit  = 1'b1;
                data = write_data[p];
            end
        end
    end

endmodule

// File: rtl/rv32_d_regfile_mp.sv
// Multi-ported RV32 register file (integer or FP flavour).
// Storage has no reset of its own. After reset or clear_i, an INIT sweep
// zeroes one entry per cycle, and reads return 0 until the sweep finishes.
module rv32_d_regfile_mp
    import rv32_d_regfile_pkg::*;
#(
    parameter int  XLEN     = DEF_XLEN,
    parameter int  NREGS    = DEF_NREGS,
    parameter int  NUM_RD   = 3,
    parameter int  NUM_WR   = 2,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic [NUM_WR-1:0]              write_enable_i,
    input  logic [NUM_WR-1:0][AW-1:0]      write_address_i,
    input  logic [NUM_WR-1:0][XLEN-1:0]    write_data_i,
    input  logic [NUM_RD-1:0][AW-1:0]      read_address_i,
    output logic [NUM_RD-1:0][XLEN-1:0]    read_data_o,
    output logic                           ready_o
);

    localparam logic [AW:0] CNT_LAST = (AW+1)'(NREGS - 1);

    rf_state_t         state_q, state_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              ready_q;
    logic [NUM_WR-1:0] write_accept;

    logic [XLEN-1:0]   mem [NREGS];

    // ---------------------------------------------------------------- FSM

    // State, sweep counter and ready flag. Reset returns to the start of the sweep.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_RUN);
        end
    end

    // Next state: sweep NREGS entries, then run. clear_i restarts the sweep from either state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                if (clear_i) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_i) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign ready_o = ready_q;

    // ------------------------------------------------------------- writes

    // A write lands only in RUN, and not on a clear or reset edge.
    // With ZERO_REG set, writes to x0 are dropped.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            write_accept[p] = write_enable_i[p] && (state_q == ST_RUN) && !clear_i && !rst_i
                              && !((ZERO_REG != 0) && (write_address_i[p] == '0));
        end
    end

    // Storage update. The sweep writes zero in INIT.
    // In RUN, ports are applied in ascending order, so the highest port wins on a collision.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            mem[cnt_q[AW-1:0]] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (write_accept[p]) begin
                    mem[write_address_i[p]] <= write_data_i[p];
                end
            end
        end
    end

    // -------------------------------------------------------------- reads

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;
        logic [XLEN-1:0] rdata;

        rv32_d_regfile_wr_arb #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NUM_WR (NUM_WR)
        ) u_arb (
            .read_address  (read_address_i[r]),
            .write_valid   (write_accept),
            .write_address (write_address_i),
            .write_data    (write_data_i),
            .hit           (byp_hit),
            .data          (byp_data)
        );

        // Read priority: INIT reads 0, then x0 (integer file) reads 0,
        // then a same-cycle write is forwarded, and otherwise the stored value is returned.
        always_comb begin
            rdata = '0;
            if (state_q != ST_RUN) begin
                rdata = '0;
            end else if ((ZERO_REG != 0) && (read_address_i[r] == '0)) begin
                rdata = '0;
            end else if (byp_hit) begin
                rdata = byp_data;
            end else begin
                rdata = mem[read_address_i[r]];
            end
        end

        assign read_data_o[r] = rdata;
    end

endmodule
